fetch_redirect_unit: RTL and testbench

Instruction fetch and PC-control block at the front of the core pipeline. It consumes the redirect outputs of the execute and decode stages (taken conditional branch, JALR target, JAL target) and drives a single-outstanding valid/ready request to instruction memory. It presents the fetched instruction and its PC to decode through a registered, stall-aware output. A redirect squashes any in-flight or buffered fetch.

---
 rtl/fetch_redirect_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// Instruction fetch / PC control: single-outstanding imem requests, redirect squash,
// and a registered stall-aware instruction output toward decode.
`timescale 1ns/1ps
module fetch_redirect_unit #(
  parameter int                       CORE         = 0,
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter int unsigned              ADDRESS_BITS = 20,
  parameter logic [ADDRESS_BITS-1:0]  RESET_PC     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    branch,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic                    jalr,
  input  logic [ADDRESS_BITS-1:0] JALR_target,
  input  logic                    jal,
  input  logic [ADDRESS_BITS-1:0] jal_target,
  output logic                    imem_req_valid,
  output logic [ADDRESS_BITS-1:0] imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_rsp_data,
  output logic                    inst_valid,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC
);

  if (CORE < 0) begin : g_core_range
  end

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_BITS-1:0] req_pc_q, req_pc_d;
  logic                    squash_q, squash_d;
  logic [DATA_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic [ADDRESS_BITS-1:0] pend_pc_q, pend_pc_d;
  logic                    inst_valid_q, inst_valid_d;
  logic [DATA_WIDTH-1:0]   instruction_q, instruction_d;
  logic [ADDRESS_BITS-1:0] inst_pc_q, inst_pc_d;

  logic                    redirect;
  logic [ADDRESS_BITS-1:0] target_raw;
  logic [ADDRESS_BITS-1:0] target;

  assign redirect = (jalr | branch | jal) && (state_q != StIdle);

  always_comb begin
    target_raw = jal_target;
    if (jalr) begin
      target_raw = JALR_target;
    end else if (branch) begin
      target_raw = branch_target;
    end
    target = {target_raw[ADDRESS_BITS-1:2], 2'b00};
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    squash_d      = squash_q;
    pend_data_d   = pend_data_q;
    pend_pc_d     = pend_pc_q;
    inst_valid_d  = inst_valid_q;
    instruction_d = instruction_q;
    inst_pc_d     = inst_pc_q;

    // Decode takes the held instruction at any edge where it is not stalling.
    if (inst_valid_q && !stall) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (imem_req_ready) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(4);
          state_d    = StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = StReq;
          end else if (!inst_valid_q || !stall) begin
            inst_valid_d  = 1'b1;
            instruction_d = imem_rsp_data;
            inst_pc_d     = req_pc_q;
            state_d       = StReq;
          end else begin
            pend_data_d = imem_rsp_data;
            pend_pc_d   = req_pc_q;
            state_d     = StHold;
          end
        end
      end
      StHold: begin
        if (!stall) begin
          inst_valid_d  = 1'b1;
          instruction_d = pend_data_q;
          inst_pc_d     = pend_pc_q;
          state_d       = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides everything above; pending data is simply abandoned.
    if (redirect) begin
      fetch_pc_d    = target;
      inst_valid_d  = 1'b0;
      instruction_d = instruction_q;
      inst_pc_d     = inst_pc_q;
      case (state_q)
        StReq: begin
          if (imem_req_ready) begin
            state_d  = StWait;
            squash_d = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
        StWait: begin
          if (imem_rsp_valid) begin
            squash_d = 1'b0;
            state_d  = StReq;
          end else begin
            squash_d = 1'b1;
            state_d  = StWait;
          end
        end
        StHold:  state_d = StReq;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      squash_q      <= 1'b0;
      pend_data_q   <= '0;
      pend_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      instruction_q <= '0;
      inst_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      squash_q      <= squash_d;
      pend_data_q   <= pend_data_d;
      pend_pc_q     <= pend_pc_d;
      inst_valid_q  <= inst_valid_d;
      instruction_q <= instruction_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = inst_valid_q;
  assign instruction    = instruction_q;
  assign inst_PC        = inst_pc_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: model memory with variable latency, a scoreboard of
// expected fetch PCs, and a second instance for address wrap-around.
`timescale 1ns/1ps
module tb_fetch_redirect_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          start, stall;
  logic          branch, jalr, jal;
  logic [AW-1:0] branch_target, jalr_target, jal_target;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          inst_valid;
  logic [DW-1:0] instruction;
  logic [AW-1:0] inst_pc;

  logic          start2;
  logic          req_valid2;
  logic [AW-1:0] req_addr2;
  logic          rsp_valid2;
  logic [DW-1:0] rsp_data2;
  logic          inst_valid2;
  logic [DW-1:0] instruction2;
  logic [AW-1:0] inst_pc2;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] sb_q[$];
  int            mem_lat;
  logic          mem_busy;
  int            mem_cnt;
  logic [AW-1:0] mem_addr;

  always #5 clock = ~clock;

  fetch_redirect_unit #(
    .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .RESET_PC(20'h00100)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .branch(branch), .branch_target(branch_target),
    .jalr(jalr), .JALR_target(jalr_target),
    .jal(jal), .jal_target(jal_target),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .inst_valid(inst_valid), .instruction(instruction), .inst_PC(inst_pc)
  );

  fetch_redirect_unit #(
    .CORE(1), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .RESET_PC(20'hFFFFC)
  ) dut_wrap (
    .clock(clock), .reset(reset), .start(start2), .stall(1'b0),
    .branch(1'b0), .branch_target('0),
    .jalr(1'b0), .JALR_target('0),
    .jal(1'b0), .jal_target('0),
    .imem_req_valid(req_valid2), .imem_req_addr(req_addr2), .imem_req_ready(1'b1),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .inst_valid(inst_valid2), .instruction(instruction2), .inst_PC(inst_pc2)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {12'h5A5, a};
  endfunction

  // Memory: latency counted in cycles after the accepting edge (1 = next cycle).
  always @(posedge clock) begin
    rsp_valid <= 1'b0;
    if (reset) begin
      mem_busy <= 1'b0;
    end else if (mem_busy) begin
      if (mem_cnt <= 1) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_word(mem_addr);
        mem_busy  <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end else if (req_valid && req_ready) begin
      if (mem_lat <= 1) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_word(req_addr);
      end else begin
        mem_busy <= 1'b1;
        mem_cnt  <= mem_lat - 1;
        mem_addr <= req_addr;
      end
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      rsp_valid2 <= 1'b0;
    end else begin
      rsp_valid2 <= req_valid2;
      rsp_data2  <= mem_word(req_addr2);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Scoreboard: every instruction decode takes must be the next expected PC.
  always begin
    @(negedge clock);
    #1;
    if (!reset && inst_valid && !stall) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_inst", 32'(sb_q.size()), 32'd1);
      end else begin
        logic [AW-1:0] exp_pc;
        exp_pc = sb_q.pop_front();
        check("sb_inst_pc", 32'(inst_pc), 32'(exp_pc));
        check("sb_instruction", instruction, mem_word(exp_pc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; stall = 1'b0;
    branch = 1'b0; jalr = 1'b0; jal = 1'b0;
    branch_target = '0; jalr_target = '0; jal_target = '0;
    req_ready = 1'b1; mem_lat = 1;
    tick(2);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_inst_pc", 32'(inst_pc), 32'd0);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_addr", 32'(req_addr), 32'h100);
    reset = 1'b0;

    // Sequential fetch with 1-cycle memory.
    sb_q.push_back(20'h100); sb_q.push_back(20'h104); sb_q.push_back(20'h108);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("e0_req_valid", 32'(req_valid), 32'd1);
    check("e0_req_addr", 32'(req_addr), 32'h100);
    tick();
    check("e1_inst_valid", 32'(inst_valid), 32'd0);
    check("e1_req_valid", 32'(req_valid), 32'd0);
    tick();
    check("e2_inst_valid", 32'(inst_valid), 32'd1);
    check("e2_inst_pc", 32'(inst_pc), 32'h100);
    tick();
    check("e3_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    check("e4_inst_pc", 32'(inst_pc), 32'h104);

    // Backpressure: 0x108 arrives while 0x104 is held.
    stall = 1'b1;
    tick(2);
    check("hold_req_valid", 32'(req_valid), 32'd0);
    check("hold_inst_valid", 32'(inst_valid), 32'd1);
    check("hold_inst_pc", 32'(inst_pc), 32'h104);
    tick();
    check("hold2_inst_pc", 32'(inst_pc), 32'h104);
    check("hold2_req_valid", 32'(req_valid), 32'd0);
    stall = 1'b0;
    tick();
    check("unhold_inst_pc", 32'(inst_pc), 32'h108);
    check("unhold_req_addr", 32'(req_addr), 32'h10C);
    mem_lat = 3;

    // Squash an outstanding fetch with jalr.
    tick();
    jalr = 1'b1; jalr_target = 20'h00203;
    sb_q.push_back(20'h200);
    tick();
    jalr = 1'b0;
    check("sq_inst_valid", 32'(inst_valid), 32'd0);
    check("sq_req_valid", 32'(req_valid), 32'd0);
    check("sq_req_addr", 32'(req_addr), 32'h200);
    tick();
    check("sq_wait_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    check("sq_drop_req_valid", 32'(req_valid), 32'd1);
    check("sq_drop_req_addr", 32'(req_addr), 32'h200);
    mem_lat = 1;
    tick(2);
    check("sq_target_inst_pc", 32'(inst_pc), 32'h200);

    // Priority: all three redirects at once.
    tick();
    jalr = 1'b1; jalr_target = 20'h400;
    branch = 1'b1; branch_target = 20'h500;
    jal = 1'b1; jal_target = 20'h600;
    sb_q.push_back(20'h400);
    tick();
    jalr = 1'b0; branch = 1'b0; jal = 1'b0;
    check("pri3_req_addr", 32'(req_addr), 32'h400);
    check("pri3_inst_valid", 32'(inst_valid), 32'd0);
    tick(2);
    check("pri3_inst_pc", 32'(inst_pc), 32'h400);
    tick();
    branch = 1'b1; jal = 1'b1;
    sb_q.push_back(20'h500);
    tick();
    branch = 1'b0; jal = 1'b0;
    check("pri2_req_addr", 32'(req_addr), 32'h500);
    tick(2);
    check("pri2_inst_pc", 32'(inst_pc), 32'h500);
    sb_q.push_back(20'h504);

    // Request held with ready low, then redirected while unaccepted.
    tick();
    req_ready = 1'b0;
    tick();
    check("rdy0_inst_pc", 32'(inst_pc), 32'h504);
    for (int i = 0; i < 3; i++) begin
      check("rdy0_req_valid", 32'(req_valid), 32'd1);
      check("rdy0_req_addr", 32'(req_addr), 32'h508);
      tick();
    end
    jal = 1'b1; jal_target = 20'h601;
    tick();
    jal = 1'b0;
    check("rdy0_redir_valid", 32'(req_valid), 32'd1);
    check("rdy0_redir_addr", 32'(req_addr), 32'h600);
    tick();
    check("rdy0_redir_stable", 32'(req_addr), 32'h600);

    // Reset while a fetch is outstanding.
    req_ready = 1'b1; mem_lat = 3;
    tick();
    check("pre_rst_req_valid", 32'(req_valid), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_instruction", instruction, 32'd0);
    check("mid_rst_inst_pc", 32'(inst_pc), 32'd0);
    check("mid_rst_req_valid", 32'(req_valid), 32'd0);
    check("mid_rst_req_addr", 32'(req_addr), 32'h100);
    tick(3);
    check("idle_req_valid", 32'(req_valid), 32'd0);
    check("idle_inst_valid", 32'(inst_valid), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    mem_lat = 1;

    // Wrap-around on the second instance.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick(2);
    check("wrap_inst_valid0", 32'(inst_valid2), 32'd1);
    check("wrap_inst_pc0", 32'(inst_pc2), 32'hFFFFC);
    check("wrap_instruction0", instruction2, mem_word(20'hFFFFC));
    tick(2);
    check("wrap_inst_valid1", 32'(inst_valid2), 32'd1);
    check("wrap_inst_pc1", 32'(inst_pc2), 32'h00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
